// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative radix-2 multiply/divide unit for the EX stage.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division. Both run one
// step per cycle on operand magnitudes and fix the signs in the final step.
// EX is held through stallreq_o while the unit runs. The {HI,LO} result comes
// back on a one-cycle done_o pulse.
// Optional feature: define MULDIV_HILO_EN to add architectural HI/LO registers
// with MTHI/MTLO write ports.
module ex_muldiv_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_W-1:0]     opa_i,
    input  logic [DATA_W-1:0]     opb_i,
    input  logic                  annul_i,
`ifdef MULDIV_HILO_EN
    input  logic [1:0]            hilo_we_i,
    input  logic [DATA_W-1:0]     hilo_wdata_i,
    output logic [DATA_W-1:0]     hi_o,
    output logic [DATA_W-1:0]     lo_o,
`endif
    output logic                  busy_o,
    output logic                  stallreq_o,
    output logic                  done_o,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  div_zero_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  div_q, div_d;        // 1: divide, 0: multiply
    logic                  sa_q, sa_d;          // dividend / multiplicand sign (signed ops only)
    logic                  sb_q, sb_d;          // divisor / multiplier sign (signed ops only)
    logic [DATA_W-1:0]     a_q, a_d;            // |opa|; shifts left as dividend bits are consumed
    logic [DATA_W-1:0]     b_q, b_d;            // |opb|; shifts right as multiplier bits are consumed
    logic [2*DATA_W-1:0]   acc_q, acc_d;        // MUL: partial product; DIV: {remainder, quotient}
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic                  done_q, done_d;
    logic                  dz_q, dz_d;

    // Two's-complement negate when n is set (DATA_W wide)
    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic n);
        return n ? (~v + DATA_W'(1)) : v;
    endfunction

    // Two's-complement negate when n is set (2*DATA_W wide)
    function automatic logic [2*DATA_W-1:0] cond_neg2(input logic [2*DATA_W-1:0] v, input logic n);
        return n ? (~v + (2*DATA_W)'(1)) : v;
    endfunction

    logic                  accept;
    logic                  in_signed;
    logic                  sa_in, sb_in;
    logic                  first_run;
    logic [DATA_W:0]       mul_sum;
    logic [2*DATA_W-1:0]   mul_acc;
    logic [DATA_W:0]       div_trial;
    logic                  div_ok;
    logic [DATA_W-1:0]     div_rem;
    logic [2*DATA_W-1:0]   div_acc;

    assign accept    = start_i & ~annul_i;
    assign in_signed = ~op_i[0];
    assign sa_in     = in_signed & opa_i[DATA_W-1];
    assign sb_in     = in_signed & opb_i[DATA_W-1];
    assign first_run = (cnt_q == CNT_W'(DATA_W));

    // One radix-2 step of each algorithm on the current registers
    always_comb begin
        // Shift-add: add the multiplicand into the upper half when the multiplier LSB is set,
        // then shift the whole accumulator right by one.
        mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (b_q[0] ? {1'b0, a_q} : '0);
        mul_acc   = {mul_sum, acc_q[DATA_W-1:1]};
        // Restoring divide: bring down the next dividend bit and keep the subtraction
        // only when it does not go negative.
        div_trial = {acc_q[2*DATA_W-1:DATA_W], a_q[DATA_W-1]} - {1'b0, b_q};
        div_ok    = ~div_trial[DATA_W];
        div_rem   = div_ok ? div_trial[DATA_W-1:0]
                           : {acc_q[2*DATA_W-2:DATA_W], a_q[DATA_W-1]};
        div_acc   = {div_rem, acc_q[DATA_W-2:0], div_ok};
    end

    // Next-state and next-register values for the control FSM and datapath
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_RUN;
                    div_d   = op_i[1];
                    sa_d    = sa_in;
                    sb_d    = sb_in;
                    a_d     = cond_neg(opa_i, sa_in);
                    b_d     = cond_neg(opb_i, sb_in);
                    acc_d   = '0;
                    cnt_d   = CNT_W'(DATA_W);
                end
            end
            S_RUN: begin
                if (annul_i) begin
                    state_d = S_IDLE;
                end else if (div_q && first_run && (b_q == '0)) begin
                    // Divide by zero: skip iterations, return the original dividend as HI.
                    state_d  = S_DONE;
                    result_d = {cond_neg(a_q, sa_q), {DATA_W{1'b1}}};
                    done_d   = 1'b1;
                    dz_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (div_q) begin
                        acc_d = div_acc;
                        a_d   = a_q << 1;
                    end else begin
                        acc_d = mul_acc;
                        b_d   = b_q >> 1;
                    end
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        // Remainder follows the dividend sign; quotient/product follow sa^sb.
                        // MIN/-1 falls out naturally as quotient=MIN, remainder=0.
                        if (div_q) begin
                            result_d = {cond_neg(div_acc[2*DATA_W-1:DATA_W], sa_q),
                                        cond_neg(div_acc[DATA_W-1:0], sa_q ^ sb_q)};
                        end else begin
                            result_d = cond_neg2(mul_acc, sa_q ^ sb_q);
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, operand, accumulator and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            div_q    <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign busy_o     = (state_q == S_RUN) || (state_q == S_DONE);
    // Low in DONE so EX advances with the result in that cycle.
    assign stallreq_o = ((state_q == S_IDLE) && accept) || (state_q == S_RUN);
    assign done_o     = done_q;
    assign result_o   = result_q;
    assign div_zero_o = dz_q;

`ifdef MULDIV_HILO_EN
    logic [DATA_W-1:0] hi_q, lo_q;

    // HI/LO update: explicit MTHI/MTLO writes override the completing result half by half
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (hilo_we_i[1]) begin
                hi_q <= hilo_wdata_i;
            end else if (done_q) begin
                hi_q <= result_q[2*DATA_W-1:DATA_W];
            end
            if (hilo_we_i[0]) begin
                lo_q <= hilo_wdata_i;
            end else if (done_q) begin
                lo_q <= result_q[DATA_W-1:0];
            end
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;
`endif

endmodule
